// File: rtl/krnl_partialknn_local_sdp_xpm_memory_uram_pipe.sv
`default_nettype none
// krnl_partialknn_local_sdp_xpm_memory_uram_pipe: simple-dual-port local tile buffer with byte-lane
// writes, a pipelined read port with valid strobe, post-reset zero clear and out-of-range flagging.
module krnl_partialknn_local_sdp_xpm_memory_uram_pipe #(
    parameter int DataWidth      = 256,
    parameter int AddressRange   = 2048,
    parameter int AddressWidth   = 11,
    parameter int READ_LATENCY   = 2,
    parameter int RDW_MODE       = 0,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [AddressWidth-1:0] address1,
    input  logic                    ce1,
    input  logic [DataWidth/8-1:0]  we1,
    input  logic [DataWidth-1:0]    d1,
    input  logic [AddressWidth-1:0] address0,
    input  logic                    ce0,
    output logic [DataWidth-1:0]    q0,
    output logic                    q0_valid,
    output logic                    clr_busy,
    output logic                    err_oob
);
    localparam int                    NUM_BYTES = DataWidth / 8;
    localparam logic [AddressWidth:0] RANGE_END = (AddressWidth + 1)'(AddressRange);
    localparam logic [AddressWidth-1:0] LAST_ADDR = AddressWidth'(AddressRange - 1);

    typedef enum logic [0:0] {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } state_t;

    state_t                  state;
    state_t                  state_next;
    logic [AddressWidth-1:0] clr_ptr;

    logic [DataWidth-1:0]    mem [AddressRange];

    logic                    run;
    logic                    oob0;
    logic                    oob1;
    logic                    rd_accept;
    logic                    wr_accept;
    logic [DataWidth-1:0]    rd_word;

    logic [DataWidth-1:0]    pipe_data [READ_LATENCY+1];
    logic [READ_LATENCY:0]   pipe_valid;

    assign run       = (state == RUN);
    assign oob0      = ({1'b0, address0} >= RANGE_END);
    assign oob1      = ({1'b0, address1} >= RANGE_END);
    assign rd_accept = run && ce0;
    assign wr_accept = run && ce1 && !oob1;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= (CLEAR_ON_RESET != 0) ? CLEAR : RUN;
            clr_ptr <= '0;
        end else begin
            state <= state_next;
            if (state == CLEAR) begin
                clr_ptr <= clr_ptr + AddressWidth'(1);
            end
        end
    end

    always_comb begin
        state_next = state;
        clr_busy   = 1'b0;
        case (state)
            CLEAR: begin
                clr_busy = 1'b1;
                if (clr_ptr == LAST_ADDR) begin
                    state_next = RUN;
                end
            end
            default: ;
        endcase
    end

    // The array itself is never reset; the clear sequencer owns the write port while active.
    always_ff @(posedge clk) begin
        if (state == CLEAR) begin
            mem[clr_ptr] <= '0;
        end else if (wr_accept) begin
            for (int b = 0; b < NUM_BYTES; b++) begin
                if (we1[b]) begin
                    mem[address1][8*b +: 8] <= d1[8*b +: 8];
                end
            end
        end
    end

    always_comb begin
        rd_word = '0;
        if (!oob0) begin
            rd_word = mem[address0];
            if (RDW_MODE == 1 && wr_accept && address1 == address0) begin
                for (int b = 0; b < NUM_BYTES; b++) begin
                    if (we1[b]) begin
                        rd_word[8*b +: 8] = d1[8*b +: 8];
                    end
                end
            end
        end
    end

    // Stage 0 captures the word at the accept edge; stages only advance data behind a valid so q0 holds.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pipe_valid <= '0;
            for (int i = 0; i <= READ_LATENCY; i++) begin
                pipe_data[i] <= '0;
            end
        end else begin
            pipe_valid[0] <= rd_accept;
            if (rd_accept) begin
                pipe_data[0] <= rd_word;
            end
            for (int i = 1; i <= READ_LATENCY; i++) begin
                pipe_valid[i] <= pipe_valid[i-1];
                if (pipe_valid[i-1]) begin
                    pipe_data[i] <= pipe_data[i-1];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            err_oob <= 1'b0;
        end else if (run && ((ce0 && oob0) || (ce1 && oob1))) begin
            err_oob <= 1'b1;
        end
    end

    assign q0       = pipe_data[READ_LATENCY];
    assign q0_valid = pipe_valid[READ_LATENCY];

endmodule
`default_nettype wire

// File: tb/tb_krnl_partialknn_local_sdp_xpm_memory_uram_pipe.sv
`default_nettype none
// Directed bench: default configuration, a 32-bit WRITE_FIRST 2000-word variant, and a
// read-latency sweep of four small no-clear instances, all sharing clock and reset.
module tb_krnl_partialknn_local_sdp_xpm_memory_uram_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n;

    int vectors     = 0;
    int miscompares = 0;

    // Default instance: 256-bit, 2048 words, latency 2, READ_FIRST.
    logic [10:0]  a_addr0, a_addr1;
    logic         a_ce0, a_ce1;
    logic [31:0]  a_we1;
    logic [255:0] a_d1, a_q0;
    logic         a_q0_valid, a_clr_busy, a_err_oob;

    // Variant: 32-bit, 2000 words, latency 3, WRITE_FIRST.
    logic [10:0]  b_addr0, b_addr1;
    logic         b_ce0, b_ce1;
    logic [3:0]   b_we1;
    logic [31:0]  b_d1, b_q0;
    logic         b_q0_valid, b_clr_busy, b_err_oob;

    // Latency sweep: 8-bit, 16 words, no clear, latency 1..4.
    logic [3:0]      c_addr0, c_addr1;
    logic            c_ce0, c_ce1;
    logic [0:0]      c_we1;
    logic [7:0]      c_d1;
    logic [3:0][7:0] c_q0;
    logic [3:0]      c_q0_valid, c_clr_busy, c_err_oob;

    krnl_partialknn_local_sdp_xpm_memory_uram_pipe u_dut_a (
        .clk(clk), .reset(rst_n),
        .address1(a_addr1), .ce1(a_ce1), .we1(a_we1), .d1(a_d1),
        .address0(a_addr0), .ce0(a_ce0), .q0(a_q0), .q0_valid(a_q0_valid),
        .clr_busy(a_clr_busy), .err_oob(a_err_oob)
    );

    krnl_partialknn_local_sdp_xpm_memory_uram_pipe #(
        .DataWidth(32), .AddressRange(2000), .AddressWidth(11),
        .READ_LATENCY(3), .RDW_MODE(1), .CLEAR_ON_RESET(1)
    ) u_dut_b (
        .clk(clk), .reset(rst_n),
        .address1(b_addr1), .ce1(b_ce1), .we1(b_we1), .d1(b_d1),
        .address0(b_addr0), .ce0(b_ce0), .q0(b_q0), .q0_valid(b_q0_valid),
        .clr_busy(b_clr_busy), .err_oob(b_err_oob)
    );

    for (genvar j = 0; j < 4; j++) begin : g_lat
        krnl_partialknn_local_sdp_xpm_memory_uram_pipe #(
            .DataWidth(8), .AddressRange(16), .AddressWidth(4),
            .READ_LATENCY(j + 1), .RDW_MODE(0), .CLEAR_ON_RESET(0)
        ) u_dut_c (
            .clk(clk), .reset(rst_n),
            .address1(c_addr1), .ce1(c_ce1), .we1(c_we1), .d1(c_d1),
            .address0(c_addr0), .ce0(c_ce0), .q0(c_q0[j]), .q0_valid(c_q0_valid[j]),
            .clr_busy(c_clr_busy[j]), .err_oob(c_err_oob[j])
        );
    end

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Called just after the accept edge; counts edges until q0_valid rises.
    task automatic wait_a(input string tag, input logic [255:0] exp);
        int lat = 0;
        while (!a_q0_valid && lat < 10) begin
            tick();
            lat++;
        end
        chk({tag, "_lat"}, 256'(lat), 256'(2));
        chk(tag, a_q0, exp);
    endtask

    task automatic wait_b(input string tag, input logic [31:0] exp);
        int lat = 0;
        while (!b_q0_valid && lat < 10) begin
            tick();
            lat++;
        end
        chk({tag, "_lat"}, 256'(lat), 256'(3));
        chk(tag, 256'(b_q0), 256'(exp));
    endtask

    task automatic wr_a(input logic [10:0] addr, input logic [255:0] data, input logic [31:0] we);
        a_addr1 = addr; a_d1 = data; a_we1 = we; a_ce1 = 1'b1;
        tick();
        a_ce1 = 1'b0;
    endtask

    task automatic rd_a(input string tag, input logic [10:0] addr, input logic [255:0] exp);
        a_addr0 = addr; a_ce0 = 1'b1;
        tick();
        a_ce0 = 1'b0;
        wait_a(tag, exp);
    endtask

    task automatic wr_b(input logic [10:0] addr, input logic [31:0] data, input logic [3:0] we);
        b_addr1 = addr; b_d1 = data; b_we1 = we; b_ce1 = 1'b1;
        tick();
        b_ce1 = 1'b0;
    endtask

    task automatic rd_b(input string tag, input logic [10:0] addr, input logic [31:0] exp);
        b_addr0 = addr; b_ce0 = 1'b1;
        tick();
        b_ce0 = 1'b0;
        wait_b(tag, exp);
    endtask

    task automatic coll_b(input string tag, input logic [31:0] data, input logic [3:0] we,
                          input logic [31:0] exp);
        b_addr1 = 11'd7; b_d1 = data; b_we1 = we; b_ce1 = 1'b1;
        b_addr0 = 11'd7; b_ce0 = 1'b1;
        tick();
        b_ce1 = 1'b0; b_ce0 = 1'b0;
        wait_b(tag, exp);
    endtask

    // Starts right after reset release; pokes a write/read to word 5 late in the clear.
    task automatic run_clear(input string tag);
        int na = 0;
        int nb = 0;
        int cyc = 0;
        logic seen = 1'b0;
        while ((a_clr_busy || b_clr_busy) && cyc < 5000) begin
            if (cyc == 2000) begin
                a_addr1 = 11'd5; a_d1 = '1; a_we1 = '1; a_ce1 = 1'b1;
                a_addr0 = 11'd5; a_ce0 = 1'b1;
            end else begin
                a_ce1 = 1'b0; a_ce0 = 1'b0;
            end
            if (a_clr_busy) na++;
            if (b_clr_busy) nb++;
            tick();
            cyc++;
            if (a_q0_valid || b_q0_valid) seen = 1'b1;
        end
        a_ce1 = 1'b0; a_ce0 = 1'b0;
        chk({tag, "_busy_a"}, 256'(na), 256'(2048));
        chk({tag, "_busy_b"}, 256'(nb), 256'(2000));
        chk({tag, "_no_valid"}, 256'(seen), 256'(0));
    endtask

    initial begin
        int clat [4];
        logic [7:0] cq [4];

        rst_n = 1'b0;
        a_addr0 = '0; a_addr1 = '0; a_ce0 = 1'b0; a_ce1 = 1'b0; a_we1 = '0; a_d1 = '0;
        b_addr0 = '0; b_addr1 = '0; b_ce0 = 1'b0; b_ce1 = 1'b0; b_we1 = '0; b_d1 = '0;
        c_addr0 = '0; c_addr1 = '0; c_ce0 = 1'b0; c_ce1 = 1'b0; c_we1 = '0; c_d1 = '0;
        repeat (3) tick();

        chk("rst_q0", a_q0, '0);
        chk("rst_valid", 256'(a_q0_valid), 256'(0));
        chk("rst_err", 256'(a_err_oob), 256'(0));
        chk("rst_busy", 256'(a_clr_busy), 256'(1));
        chk("rst_busy_noclr", 256'(c_clr_busy[0]), 256'(0));

        rst_n = 1'b1;
        run_clear("clr1");

        rd_a("clr_0", 11'd0, '0);
        rd_a("clr_1023", 11'd1023, '0);
        rd_a("clr_2047", 11'd2047, '0);
        rd_a("clr_poke5", 11'd5, '0);

        wr_a(11'd10, {32{8'hA5}}, '1);
        rd_a("wr_a5", 11'd10, {32{8'hA5}});

        wr_a(11'd20, '1, '1);
        wr_a(11'd20, '0, 32'h0000_0003);
        rd_a("mask", 11'd20, {{240{1'b1}}, 16'h0000});

        wr_a(11'd7, {32{8'h11}}, '1);
        a_addr1 = 11'd7; a_d1 = {32{8'h22}}; a_we1 = '1; a_ce1 = 1'b1;
        a_addr0 = 11'd7; a_ce0 = 1'b1;
        tick();
        a_ce1 = 1'b0; a_ce0 = 1'b0;
        wait_a("coll_rf", {32{8'h11}});
        rd_a("coll_commit", 11'd7, {32{8'h22}});

        // Back-to-back reads, then q0 must hold once the strobe drops.
        a_addr0 = 11'd10; a_ce0 = 1'b1;
        tick();
        a_addr0 = 11'd20;
        tick();
        a_ce0 = 1'b0;
        tick();
        chk("b2b_v1", 256'(a_q0_valid), 256'(1));
        chk("b2b_d1", a_q0, {32{8'hA5}});
        tick();
        chk("b2b_v2", 256'(a_q0_valid), 256'(1));
        chk("b2b_d2", a_q0, {{240{1'b1}}, 16'h0000});
        tick();
        chk("hold_v", 256'(a_q0_valid), 256'(0));
        chk("hold_d", a_q0, {{240{1'b1}}, 16'h0000});
        chk("a_err_clean", 256'(a_err_oob), 256'(0));

        wr_b(11'd7, 32'h1111_1111, 4'hF);
        coll_b("b_coll_full", 32'h2222_2222, 4'hF, 32'h2222_2222);
        coll_b("b_coll_byte", 32'h0000_00AA, 4'h1, 32'h2222_22AA);
        rd_b("b_commit", 11'd7, 32'h2222_22AA);

        chk("b_err_pre", 256'(b_err_oob), 256'(0));
        b_addr0 = 11'd2000; b_ce0 = 1'b1;
        tick();
        b_ce0 = 1'b0;
        chk("b_err_set", 256'(b_err_oob), 256'(1));
        wait_b("b_oob_read", 32'h0);
        repeat (5) tick();
        chk("b_err_sticky", 256'(b_err_oob), 256'(1));

        wr_b(11'd47, 32'h4747_4747, 4'hF);
        wr_b(11'd2047, 32'hDEAD_BEEF, 4'hF);
        rd_b("b_word47", 11'd47, 32'h4747_4747);

        c_addr1 = 4'd3; c_d1 = 8'h5A; c_we1 = 1'b1; c_ce1 = 1'b1;
        tick();
        c_ce1 = 1'b0;
        c_addr0 = 4'd3; c_ce0 = 1'b1;
        tick();
        c_ce0 = 1'b0;
        for (int j = 0; j < 4; j++) begin
            clat[j] = -1;
            cq[j] = 8'h00;
        end
        for (int t = 0; t <= 6; t++) begin
            for (int j = 0; j < 4; j++) begin
                if (c_q0_valid[j] && clat[j] < 0) begin
                    clat[j] = t;
                    cq[j] = c_q0[j];
                end
            end
            tick();
        end
        for (int j = 0; j < 4; j++) begin
            chk($sformatf("sweep_lat%0d", j + 1), 256'(clat[j]), 256'(j + 1));
            chk($sformatf("sweep_q%0d", j + 1), 256'(cq[j]), 256'(8'h5A));
        end

        // Reset with two reads in flight.
        a_addr0 = 11'd10; a_ce0 = 1'b1;
        tick();
        a_addr0 = 11'd20;
        tick();
        a_ce0 = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", 256'(a_q0_valid), 256'(0));
        chk("mid_rst_q0", a_q0, '0);
        chk("mid_rst_err_b", 256'(b_err_oob), 256'(0));
        chk("mid_rst_busy", 256'(a_clr_busy), 256'(1));
        repeat (3) tick();
        rst_n = 1'b1;
        run_clear("clr2");
        rd_a("reclr_10", 11'd10, '0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
